// File: rtl/spi_command_sequencer.sv
// Decodes the SPI byte stream into sprite-RAM writes and packed draw requests.
// Optional build macro: SPRITE_BOUNDS_CHECK_EN rejects sprite ids >= NUM_SPRITES.
module spi_command_sequencer #(
    parameter int NUM_SPRITES = 64,
    parameter int SPRITE_BYTES = 512,
    parameter int DRAW_ARGS = 6,
    parameter logic [7:0] COMMAND_SAVE_SPRITE = 8'h01,
    parameter logic [7:0] COMMAND_DRAW_SPRITE = 8'h02,
    localparam int ID_W = $clog2(NUM_SPRITES),
    localparam int PIX_W = $clog2(SPRITE_BYTES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_active,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  spr_wr_valid,
    input  logic                  spr_wr_ready,
    output logic [ID_W+PIX_W-1:0] spr_wr_addr,
    output logic [7:0]            spr_wr_data,
    output logic                  draw_valid,
    input  logic                  draw_ready,
    output logic [7:0]            draw_id,
    output logic [15:0]           draw_x,
    output logic [15:0]           draw_y,
    output logic [7:0]            draw_flags,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  err_clear
);

    localparam int ARG_W = $clog2(DRAW_ARGS);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SPRITE_BYTES - 1);
    localparam logic [ARG_W-1:0] ARG_LAST = ARG_W'(DRAW_ARGS - 1);
    localparam logic [7:0] ID_MASK = 8'((1 << ID_W) - 1);

    typedef enum logic [1:0] {IDLE, SAVE_ID, SAVE_PIX, DRAW_ARG} state_t;

    state_t           state, next_state;
    logic [PIX_W-1:0] pix_cnt;
    logic [ARG_W-1:0] arg_cnt;
    logic [ID_W-1:0]  sprite_id;
    logic             save_discard;
    logic [7:0]       arg_id;
    logic [15:0]      arg_x, arg_y;
    logic             take, id_oob, draw_oob;
    logic             wr_load, wr_fire, wr_drop;
    logic             draw_done, draw_load, draw_fire, draw_drop;
    logic             bounds_err;

    assign take = byte_valid && frame_active;

`ifdef SPRITE_BOUNDS_CHECK_EN
    assign id_oob   = {1'b0, byte_data} >= 9'(NUM_SPRITES);
    assign draw_oob = {1'b0, arg_id} >= 9'(NUM_SPRITES);
`else
    assign id_oob   = 1'b0;
    assign draw_oob = 1'b0;
`endif

    assign wr_load    = take && (state == SAVE_PIX) && !save_discard;
    assign wr_fire    = spr_wr_valid && spr_wr_ready;
    assign wr_drop    = wr_load && spr_wr_valid && !spr_wr_ready;
    assign draw_done  = take && (state == DRAW_ARG) && (arg_cnt == ARG_LAST);
    assign draw_load  = draw_done && !draw_oob;
    assign draw_fire  = draw_valid && draw_ready;
    assign draw_drop  = draw_load && draw_valid && !draw_ready;
    assign bounds_err = (take && (state == SAVE_ID) && id_oob) || (draw_done && draw_oob);
    assign busy       = (state != IDLE) || spr_wr_valid || draw_valid;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A dropped chip-select abandons any partially received command.
    always_comb begin
        next_state = state;
        if (!frame_active && state != IDLE) begin
            next_state = IDLE;
        end else if (take) begin
            case (state)
                IDLE: begin
                    if (byte_data == COMMAND_SAVE_SPRITE)      next_state = SAVE_ID;
                    else if (byte_data == COMMAND_DRAW_SPRITE) next_state = DRAW_ARG;
                end
                SAVE_ID:  next_state = SAVE_PIX;
                SAVE_PIX: if (pix_cnt == PIX_LAST) next_state = IDLE;
                DRAW_ARG: if (arg_cnt == ARG_LAST) next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt      <= '0;
            arg_cnt      <= '0;
            sprite_id    <= '0;
            save_discard <= 1'b0;
            arg_id       <= '0;
            arg_x        <= '0;
            arg_y        <= '0;
        end else begin
            if (state == IDLE) arg_cnt <= '0;
            if (take) begin
                case (state)
                    SAVE_ID: begin
                        sprite_id    <= byte_data[ID_W-1:0];
                        save_discard <= id_oob;
                        pix_cnt      <= '0;
                    end
                    SAVE_PIX: pix_cnt <= pix_cnt + 1'b1;
                    DRAW_ARG: begin
                        arg_cnt <= arg_cnt + 1'b1;
                        case (arg_cnt)
                            ARG_W'(0): arg_id      <= byte_data;
                            ARG_W'(1): arg_x[15:8] <= byte_data;
                            ARG_W'(2): arg_x[7:0]  <= byte_data;
                            ARG_W'(3): arg_y[15:8] <= byte_data;
                            ARG_W'(4): arg_y[7:0]  <= byte_data;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Single-entry buffers: reload in the same cycle as a handshake, drop if still occupied.
    always_ff @(posedge clock) begin
        if (reset) begin
            spr_wr_valid <= 1'b0;
            spr_wr_addr  <= '0;
            spr_wr_data  <= '0;
        end else if (wr_load && (!spr_wr_valid || spr_wr_ready)) begin
            spr_wr_valid <= 1'b1;
            spr_wr_addr  <= {sprite_id, pix_cnt};
            spr_wr_data  <= byte_data;
        end else if (wr_fire) begin
            spr_wr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            draw_valid <= 1'b0;
            draw_id    <= '0;
            draw_x     <= '0;
            draw_y     <= '0;
            draw_flags <= '0;
        end else if (draw_load && (!draw_valid || draw_ready)) begin
            draw_valid <= 1'b1;
            draw_id    <= arg_id & ID_MASK;
            draw_x     <= arg_x;
            draw_y     <= arg_y;
            draw_flags <= byte_data;
        end else if (draw_fire) begin
            draw_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                                  overflow <= 1'b0;
        else if (wr_drop || draw_drop || bounds_err) overflow <= 1'b1;
        else if (err_clear)                         overflow <= 1'b0;
    end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Self-checking bench for spi_command_sequencer: table-driven draws, stall/abort sequences,
// and randomized frames scored against a command-level expectation queue.
module tb_spi_command_sequencer;

    localparam int ID_W = 6;
    localparam int PIX_W = 9;
    localparam logic [7:0] OP_SAVE = 8'h01;
    localparam logic [7:0] OP_DRAW = 8'h02;

    logic              clock, reset, frame_active, byte_valid;
    logic [7:0]        byte_data;
    logic              spr_wr_valid, spr_wr_ready;
    logic [ID_W+PIX_W-1:0] spr_wr_addr;
    logic [7:0]        spr_wr_data;
    logic              draw_valid, draw_ready;
    logic [7:0]        draw_id, draw_flags;
    logic [15:0]       draw_x, draw_y;
    logic              busy, overflow, err_clear;

    spi_command_sequencer dut (
        .clock(clock), .reset(reset), .frame_active(frame_active),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .spr_wr_valid(spr_wr_valid), .spr_wr_ready(spr_wr_ready),
        .spr_wr_addr(spr_wr_addr), .spr_wr_data(spr_wr_data),
        .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_id(draw_id), .draw_x(draw_x), .draw_y(draw_y), .draw_flags(draw_flags),
        .busy(busy), .overflow(overflow), .err_clear(err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [22:0] wr_q[$];
    logic [47:0] draw_q[$];

    typedef struct {
        logic [7:0]  args[6];
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
    } draw_vec_t;
    draw_vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (wr_q.size() == 0 && draw_q.size() == 0 && !busy) break;
            tick();
        end
        checkOutput(name, {77'd0, busy, wr_q.size() != 0, draw_q.size() != 0}, 80'd0);
    endtask

    task automatic pulseClear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    // Handshakes are scored on the falling edge, before the rising edge that completes them.
    always @(negedge clock) begin
        if (!reset) begin
            if (spr_wr_valid && spr_wr_ready) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_write: got addr=%0h data=%0h, required none", spr_wr_addr, spr_wr_data);
                end else begin
                    checkOutput("spr_write", {57'd0, spr_wr_addr, spr_wr_data}, {57'd0, wr_q.pop_front()});
                end
            end
            if (draw_valid && draw_ready) begin
                if (draw_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_draw: got id=%0h x=%0d y=%0d, required none", draw_id, draw_x, draw_y);
                end else begin
                    checkOutput("draw_req", {32'd0, draw_id, draw_x, draw_y, draw_flags}, {32'd0, draw_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendDraw(input logic [7:0] a[6], input bit expect_issue);
        applyStimulus(OP_DRAW, 0);
        if (expect_issue) draw_q.push_back({a[0] & 8'h3F, a[1], a[2], a[3], a[4], a[5]});
        for (int i = 0; i < 6; i++) applyStimulus(a[i], 0);
    endtask

    initial begin
        logic [7:0] a[6];
        logic [7:0] b, sid;
        int kind, k, gap;

        vecs[0].args = '{8'h05, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h02};
        vecs[0].id = 8'h05; vecs[0].x = 16'd300; vecs[0].y = 16'd200; vecs[0].flags = 8'h02;
        vecs[1].args = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].id = 8'h00; vecs[1].x = 16'h0000; vecs[1].y = 16'h0000; vecs[1].flags = 8'h00;
        vecs[2].args = '{8'h3F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2].id = 8'h3F; vecs[2].x = 16'hFFFF; vecs[2].y = 16'hFFFF; vecs[2].flags = 8'hFF;
        vecs[3].args = '{8'h12, 8'hAB, 8'hCD, 8'h01, 8'h02, 8'h80};
        vecs[3].id = 8'h12; vecs[3].x = 16'hABCD; vecs[3].y = 16'h0102; vecs[3].flags = 8'h80;

        reset = 1'b1; frame_active = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        spr_wr_ready = 1'b1; draw_ready = 1'b1; err_clear = 1'b0;
        repeat (3) tick();
        checkOutput("reset_outputs",
            {5'd0, spr_wr_valid, spr_wr_addr, spr_wr_data, draw_valid, draw_id, draw_x, draw_y,
             draw_flags, busy, overflow}, 80'd0);
        reset = 1'b0;
        tick();

        $display("[TB] full sprite save");
        frame_active = 1'b1;
        applyStimulus(OP_SAVE, 0);
        applyStimulus(8'h03, 0);
        for (int i = 0; i < 512; i++) begin
            wr_q.push_back({6'd3, 9'(i), 8'(i)});
            applyStimulus(8'(i), 0);
            if (i == 0)
                checkOutput("wr_first_latency", {56'd0, spr_wr_valid, spr_wr_addr, spr_wr_data},
                            {56'd0, 1'b1, 6'd3, 9'd0, 8'h00});
        end
        drain("save_drain");
        checkOutput("save_no_overflow", {79'd0, overflow}, 80'd0);

        $display("[TB] table-driven draws");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(OP_DRAW, 0);
            draw_q.push_back({vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].flags});
            for (int i = 0; i < 6; i++) applyStimulus(vecs[v].args[i], 0);
            checkOutput("draw_latency", {79'd0, draw_valid}, 80'd1);
            drain("draw_table_drain");
        end

        $display("[TB] write stall and drop");
        spr_wr_ready = 1'b0;
        applyStimulus(OP_SAVE, 0);
        applyStimulus(8'h07, 0);
        wr_q.push_back({6'd7, 9'd0, 8'h11});
        applyStimulus(8'h11, 0);
        checkOutput("stall_first", {56'd0, spr_wr_valid, spr_wr_addr, spr_wr_data}, {56'd0, 1'b1, 6'd7, 9'd0, 8'h11});
        applyStimulus(8'h22, 1);
        checkOutput("stall_hold", {56'd0, spr_wr_valid, spr_wr_addr, spr_wr_data}, {56'd0, 1'b1, 6'd7, 9'd0, 8'h11});
        checkOutput("stall_overflow", {79'd0, overflow}, 80'd1);
        frame_active = 1'b0;
        repeat (2) tick();
        checkOutput("abort_keeps_write", {79'd0, spr_wr_valid}, 80'd1);
        spr_wr_ready = 1'b1;
        drain("stall_drain");
        checkOutput("overflow_sticky", {79'd0, overflow}, 80'd1);
        pulseClear();
        checkOutput("overflow_cleared", {79'd0, overflow}, 80'd0);

        $display("[TB] draw stall and drop");
        frame_active = 1'b1;
        draw_ready = 1'b0;
        a = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h20, 8'h03};
        sendDraw(a, 1'b1);
        a = '{8'h09, 8'h00, 8'h11, 8'h00, 8'h21, 8'h04};
        sendDraw(a, 1'b0);
        checkOutput("draw_hold", {32'd0, draw_id, draw_x, draw_y, draw_flags}, {32'd0, 8'h01, 16'h0010, 16'h0020, 8'h03});
        checkOutput("draw_overflow", {79'd0, overflow}, 80'd1);
        draw_ready = 1'b1;
        drain("draw_stall_drain");
        pulseClear();

        $display("[TB] abort mid draw then new frame");
        applyStimulus(OP_DRAW, 0);
        applyStimulus(8'h09, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h10, 0);
        frame_active = 1'b0;
        repeat (2) tick();
        frame_active = 1'b1;
        a = '{8'h0A, 8'h00, 8'h20, 8'h00, 8'h30, 8'h04};
        sendDraw(a, 1'b1);
        drain("abort_draw_drain");

        $display("[TB] unknown opcode then draw");
        applyStimulus(8'hAA, 0);
        a = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h06, 8'h07};
        sendDraw(a, 1'b1);
        drain("unknown_op_drain");
        frame_active = 1'b0;
        tick();

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            frame_active = 1'b1;
            if (kind <= 2) begin
                k = $urandom_range(1, 5);
                for (int i = 0; i < k; i++) begin
                    b = 8'($urandom);
                    if (b == OP_SAVE || b == OP_DRAW) b = 8'hAA;
                    applyStimulus(b, $urandom_range(0, 2));
                end
            end else if (kind <= 7) begin
                k = (kind <= 5) ? 6 : $urandom_range(0, 5);
                for (int i = 0; i < 6; i++) a[i] = 8'($urandom);
                a[0] = 8'($urandom_range(0, 63));
                applyStimulus(OP_DRAW, $urandom_range(0, 2));
                if (k == 6) draw_q.push_back({a[0], a[1], a[2], a[3], a[4], a[5]});
                for (int i = 0; i < k; i++) applyStimulus(a[i], $urandom_range(0, 2));
            end else begin
                k = (kind == 9) ? 512 : $urandom_range(1, 30);
                sid = 8'($urandom_range(0, 63));
                applyStimulus(OP_SAVE, $urandom_range(0, 2));
                applyStimulus(sid, $urandom_range(0, 2));
                for (int i = 0; i < k; i++) begin
                    b = 8'($urandom);
                    gap = $urandom_range(0, 2);
                    wr_q.push_back({sid[5:0], 9'(i), b});
                    applyStimulus(b, gap);
                end
            end
            frame_active = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        drain("random_drain");
        checkOutput("random_no_overflow", {79'd0, overflow}, 80'd0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
